// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath
module rv_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    input  logic       cmp_ltu,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] imm_sel,
    output logic [3:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic [2:0] state
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    state_t cur, nxt;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal, taken;
    logic [3:0] arith;
    assign is_r     = opcode == OP_R;
    assign is_i     = opcode == OP_I;
    assign is_ld    = opcode == OP_LD;
    assign is_st    = opcode == OP_ST;
    assign is_br    = opcode == OP_BR;
    assign is_jal   = opcode == OP_JAL;
    assign is_jalr  = opcode == OP_JALR;
    assign is_lui   = opcode == OP_LUI;
    assign is_auipc = opcode == OP_AUIPC;
    assign legal = (is_r || is_i || is_jal || is_jalr || is_lui || is_auipc ||
                    (is_br && func3[2:1] != 2'b01) ||
                    (is_ld && func3 != 3'b011 && func3[2:1] != 2'b11) ||
                    (is_st && func3 <= 3'd2));
    assign state = cur;
    // ALU operation for R-type and I-ALU; func7_5 selects SUB only for R-type, SRA for both
    always_comb begin
        case (func3)
            3'b000:  arith = (is_r && func7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith = ALU_SLL;
            3'b010:  arith = ALU_SLT;
            3'b011:  arith = ALU_SLTU;
            3'b100:  arith = ALU_XOR;
            3'b101:  arith = func7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith = ALU_OR;
            default: arith = ALU_AND;
        endcase
    end
    // Branch condition from the comparator flags
    always_comb begin
        case (func3)
            3'b000:  taken = cmp_eq;
            3'b001:  taken = !cmp_eq;
            3'b100:  taken = cmp_lt;
            3'b101:  taken = !cmp_lt;
            3'b110:  taken = cmp_ltu;
            3'b111:  taken = !cmp_ltu;
            default: taken = 1'b0;
        endcase
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= FETCH;
        else        cur <= nxt;
    end
    // Next state and datapath strobes; fetch strobes are gated by rst_n so they drop during reset
    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        imm_sel   = IMM_I;
        alu_op    = ALU_ADD;
        wb_sel    = 2'd0;
        halted    = 1'b0;
        case (cur)
            FETCH: begin
                imem_req = rst_n;
                ir_we    = rst_n && imem_ack;
                if (imem_ack) nxt = DECODE;
            end
            DECODE: nxt = legal ? EXEC : HALT;
            EXEC: begin
                if (is_br) begin
                    imm_sel = IMM_B;
                    pc_we   = 1'b1;
                    pc_src  = taken ? 2'd1 : 2'd0;
                    nxt     = FETCH;
                end else if (is_ld || is_st) begin
                    alu_b_sel = 1'b1;
                    imm_sel   = is_st ? IMM_S : IMM_I;
                    nxt       = MEM;
                end else begin
                    nxt       = WB;
                    alu_op    = is_lui ? ALU_PASSB : (is_r || is_i) ? arith : ALU_ADD;
                    alu_a_sel = is_auipc;
                    alu_b_sel = is_i || is_lui || is_auipc;
                    imm_sel   = (is_lui || is_auipc) ? IMM_U : IMM_I;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) begin
                    pc_we = is_st;
                    nxt   = is_st ? FETCH : WB;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
                pc_src  = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                imm_sel = is_jal ? IMM_J : IMM_I;
                nxt     = FETCH;
            end
            HALT: halted = 1'b1;
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: trace-based randomized check of the multi-cycle controller
module tb_rv_multicycle_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic func7_5 = 1'b0, cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, alu_a_sel, alu_b_sel, halted;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] imm_sel, state;
    logic [3:0] alu_op;
    logic [22:0] bus;
    int n_tests = 0, n_fail = 0;
    logic [3:0] rtab [16] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                              4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    rv_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7_5(func7_5),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm_sel(imm_sel),
        .alu_op(alu_op), .wb_sel(wb_sel), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;
    assign bus = {state, halted, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src,
                  alu_a_sel, alu_b_sel, imm_sel, alu_op, wb_sel};

    function automatic logic [22:0] pk(input logic [2:0] st, input logic h, rq, iw, dr, dw, rw, pw,
                                       input logic [1:0] ps, input logic a, b, input logic [2:0] im,
                                       input logic [3:0] op, input logic [1:0] wb);
        return {st, h, rq, iw, dr, dw, rw, pw, ps, a, b, im, op, wb};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1 check("in_reset", 32'(bus), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("after_release", 32'(bus), 32'(pk(0,0,1,0,0,0,0,0,0,0,0,0,0,0)));
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int wi, wd,
                             input logic eq, lt, ltu, input int abort_at);
        logic [22:0] exp_q[$];
        bit ia_q[$], da_q[$];
        bit r, i, ld, st, br, jal, jalr, lui, aui, legal, taken, left;
        logic [22:0] ex, tail;
        int expected, obs_cyc;
        r = op == 7'h33; i = op == 7'h13; ld = op == 7'h03; st = op == 7'h23; br = op == 7'h63;
        jal = op == 7'h6F; jalr = op == 7'h67; lui = op == 7'h37; aui = op == 7'h17;
        legal = (r | i | ld | st | br | jal | jalr | lui | aui) && !(br && (f3 == 2 || f3 == 3))
                && !(ld && (f3 == 3 || f3 >= 6)) && !(st && f3 > 2);
        taken = f3 == 0 ? eq : f3 == 1 ? !eq : f3 == 4 ? lt : f3 == 5 ? !lt : f3 == 6 ? ltu : !ltu;
        opcode = op; func3 = f3; func7_5 = f7; cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
        for (int n = 0; n < wi; n++) begin
            exp_q.push_back(pk(0,0,1,0,0,0,0,0,0,0,0,0,0,0)); ia_q.push_back(0); da_q.push_back(1'($urandom_range(0,1)));
        end
        exp_q.push_back(pk(0,0,1,1,0,0,0,0,0,0,0,0,0,0)); ia_q.push_back(1); da_q.push_back(1'($urandom_range(0,1)));
        exp_q.push_back(pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)); ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(1'($urandom_range(0,1)));
        if (!legal) begin
            for (int n = 0; n < 6; n++) begin
                exp_q.push_back(pk(5,1,0,0,0,0,0,0,0,0,0,0,0,0)); ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(1'($urandom_range(0,1)));
            end
        end else begin
            if (br)        ex = pk(2,0,0,0,0,0,0,1, taken ? 2'd1 : 2'd0, 0,0,2,0,0);
            else if (ld)   ex = pk(2,0,0,0,0,0,0,0,0,0,1,0,0,0);
            else if (st)   ex = pk(2,0,0,0,0,0,0,0,0,0,1,1,0,0);
            else if (lui)  ex = pk(2,0,0,0,0,0,0,0,0,0,1,4,10,0);
            else if (aui)  ex = pk(2,0,0,0,0,0,0,0,0,1,1,4,0,0);
            else if (r)    ex = pk(2,0,0,0,0,0,0,0,0,0,0,0,rtab[{f7, f3}],0);
            else if (i)    ex = pk(2,0,0,0,0,0,0,0,0,0,1,0,rtab[{f3 == 5 ? f7 : 1'b0, f3}],0);
            else           ex = pk(2,0,0,0,0,0,0,0,0,0,0,0,0,0);
            exp_q.push_back(ex); ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(1'($urandom_range(0,1)));
            if (ld || st) begin
                for (int n = 0; n < wd; n++) begin
                    exp_q.push_back(pk(3,0,0,0,1,st,0,0,0,0,0,0,0,0)); ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(0);
                end
                exp_q.push_back(pk(3,0,0,0,1,st,0,st,0,0,0,0,0,0)); ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(1);
            end
            if (!br && !st) begin
                exp_q.push_back(pk(4,0,0,0,0,0,1,1, jal ? 2'd1 : jalr ? 2'd2 : 2'd0, 0,0, jal ? 3'd3 : 3'd0, 0,
                                   ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0));
                ia_q.push_back(1'($urandom_range(0,1))); da_q.push_back(1'($urandom_range(0,1)));
            end
        end
        expected = (br ? 3 : ld ? 5 : 4) + wi + ((ld || st) ? wd : 0);
        tail = legal ? pk(0,0,1,0,0,0,0,0,0,0,0,0,0,0) : pk(5,1,0,0,0,0,0,0,0,0,0,0,0,0);
        left = 0;
        obs_cyc = -1;
        for (int k = 0; k <= exp_q.size(); k++) begin
            @(negedge clk);
            imem_ack = k < exp_q.size() ? ia_q[k] : 1'b0;
            dmem_ack = k < exp_q.size() ? da_q[k] : 1'b0;
            #1 check($sformatf("cyc%0d_op%h_f3%0d", k, op, f3), 32'(bus), 32'(k < exp_q.size() ? exp_q[k] : tail));
            if (state != 3'd0) left = 1;
            else if (left && obs_cyc < 0) obs_cyc = k;
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check("abort_async", 32'(bus), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
                @(posedge clk);
                #1 check("abort_held", 32'(bus), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
                @(negedge clk);
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
                rst_n = 1'b1;
                #1 check("abort_release", 32'(bus), 32'(pk(0,0,1,0,0,0,0,0,0,0,0,0,0,0)));
                return;
            end
        end
        if (legal) check($sformatf("ncyc_op%h", op), 32'(obs_cyc), 32'(expected));
        else do_reset();
    endtask

    initial begin
        logic [31:0] rv;
        logic [6:0] op;
        do_reset();
        run_instr(7'h33, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h63, 3'd0, 1'b0, 0, 0, 1, 0, 0, -1);
        run_instr(7'h63, 3'd0, 1'b0, 0, 0, 0, 1, 1, -1);
        run_instr(7'h03, 3'd2, 1'b0, 0, 3, 0, 0, 0, -1);
        run_instr(7'h33, 3'd0, 1'b1, 1, 0, 0, 0, 0, -1);
        run_instr(7'h13, 3'd5, 1'b1, 0, 0, 0, 0, 0, -1);
        run_instr(7'h13, 3'd5, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h13, 3'd0, 1'b1, 0, 0, 0, 0, 0, -1);
        run_instr(7'h6F, 3'd0, 1'b0, 2, 0, 0, 0, 0, -1);
        run_instr(7'h67, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h37, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h17, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h7F, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h63, 3'd2, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr(7'h23, 3'd2, 1'b0, 1, 3, 0, 0, 0, 4);
        run_instr(7'h23, 3'd2, 1'b0, 0, 1, 0, 0, 0, -1);
        for (int n = 0; n < 200; n++) begin
            rv = $urandom;
            op = rv[4:0] < 5'd27 ? ops[rv[4:0] % 9] : rv[11:5];
            run_instr(op, rv[14:12], rv[15], int'(rv[17:16]), int'(rv[19:18]), rv[20], rv[21], rv[22], -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
